mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Two-master (fetch/EXE) SRAM-like arbiter onto one shared port,
//               with in-order response routing via a tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int OST_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic [2:0]  ost_cnt,
    output logic        resp_err
);

    localparam logic [2:0] c_depth      = 3'(OST_DEPTH);
    localparam logic [2:0] c_starve_max = 3'(STARVE_MAX);
    localparam logic [1:0] c_last_ptr   = 2'(OST_DEPTH - 1);

    typedef enum logic [0:0] {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    logic [2:0] r_cnt;
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [3:0] r_tags;
    logic       r_lock;
    grant_t     r_lock_grant;
    logic [2:0] r_starve;
    logic       r_resp_err;

    grant_t     w_grant;
    logic       w_full;
    logic       w_sel_req;
    logic       w_push;
    logic       w_pop;
    logic       w_head;

    always_comb begin
        w_full = (r_cnt == c_depth);

        // A presented-but-unaccepted request keeps its grant so the bus stays stable
        if (r_lock)
            w_grant = r_lock_grant;
        else if (data_req && !(r_starve == c_starve_max && inst_req))
            w_grant = GNT_DATA;
        else
            w_grant = GNT_INST;

        w_sel_req = (w_grant == GNT_DATA) ? data_req : inst_req;
        mem_req   = w_sel_req & ~w_full & ~reset;

        if (w_grant == GNT_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wstrb = inst_wstrb;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end

        inst_addr_ok = mem_req & mem_addr_ok & (w_grant == GNT_INST);
        data_addr_ok = mem_req & mem_addr_ok & (w_grant == GNT_DATA);

        w_push = mem_req & mem_addr_ok;
        w_pop  = mem_data_ok & (r_cnt != 3'd0) & ~reset;
        w_head = r_tags[r_rd_ptr];

        inst_data_ok = w_pop & ~w_head;
        data_data_ok = w_pop &  w_head;

        inst_rdata = mem_rdata;
        data_rdata = mem_rdata;
        ost_cnt    = r_cnt;
        resp_err   = r_resp_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 3'd0;
            r_wr_ptr     <= 2'd0;
            r_rd_ptr     <= 2'd0;
            r_tags       <= 4'd0;
            r_lock       <= 1'b0;
            r_lock_grant <= GNT_INST;
            r_starve     <= 3'd0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= (w_grant == GNT_DATA);
                r_wr_ptr         <= (r_wr_ptr == c_last_ptr) ? 2'd0 : r_wr_ptr + 2'd1;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? 2'd0 : r_rd_ptr + 2'd1;

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase

            r_lock       <= mem_req & ~mem_addr_ok;
            r_lock_grant <= w_grant;

            if (!inst_req)
                r_starve <= 3'd0;
            else if (w_push && w_grant == GNT_INST)
                r_starve <= 3'd0;
            else if (w_push && r_starve < c_starve_max)
                r_starve <= r_starve + 3'd1;

            if (mem_data_ok && r_cnt == 3'd0)
                r_resp_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// Testbench for mem_req_arbiter: random SRAM-like traffic against a
// queue-based reference model, plus directed starvation and error scenarios.
module tb_mem_req_arbiter;

    localparam int OST_DEPTH  = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  ost_cnt;
    logic        resp_err;

    mem_req_arbiter #(.OST_DEPTH(OST_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .ost_cnt(ost_cnt), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding tags in order (0 = inst, 1 = data)
    bit exp_q[$];
    int m_lock   = -1;
    int m_starve = 0;
    bit m_err    = 1'b0;
    bit popped;
    bit mon_tag;
    bit inst_acc, data_acc;
    bit log_en = 1'b0;
    bit grant_log[$];
    int g;
    bit m_full, m_req, m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the expected tag whenever the downstream responds
    always @(negedge clk) begin
        popped = 1'b0;
        chk("ost_cnt", 32'(ost_cnt), 32'(exp_q.size()));
        chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("inst_rdata", inst_rdata, mem_rdata);
        chk("data_rdata", data_rdata, mem_rdata);
        if (!reset && mem_data_ok && exp_q.size() > 0) begin
            mon_tag = exp_q.pop_front();
            popped  = 1'b1;
            chk("inst_data_ok", 32'(inst_data_ok), 32'(!mon_tag));
            chk("data_data_ok", 32'(data_data_ok), 32'(mon_tag));
        end else begin
            if (!reset && mem_data_ok) m_err = 1'b1;
            chk("inst_data_ok_idle", 32'(inst_data_ok), 32'd0);
            chk("data_data_ok_idle", 32'(data_data_ok), 32'd0);
        end
    end

    // Request-side predictor: arbitration from the priority/lock/starvation rules
    always @(negedge clk) begin
        #1;
        if (m_lock >= 0) g = m_lock;
        else if (data_req && !(m_starve == STARVE_MAX && inst_req)) g = 1;
        else g = 0;
        m_full = (exp_q.size() + int'(popped)) == OST_DEPTH;
        m_req  = (g == 1 ? data_req : inst_req) && !m_full && !reset;
        m_acc  = m_req && mem_addr_ok;
        chk("mem_req", 32'(mem_req), 32'(m_req));
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(m_acc && g == 0));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(m_acc && g == 1));
        if (m_req) begin
            chk("mem_addr", mem_addr, g == 1 ? data_addr : inst_addr);
            chk("mem_wdata", mem_wdata, g == 1 ? data_wdata : inst_wdata);
            chk("mem_ctrl", 32'({mem_wr, mem_size, mem_wstrb}),
                g == 1 ? 32'({data_wr, data_size, data_wstrb}) : 32'({inst_wr, inst_size, inst_wstrb}));
        end
        if (log_en && (inst_addr_ok || data_addr_ok)) grant_log.push_back(data_addr_ok);
        inst_acc = m_acc && g == 0;
        data_acc = m_acc && g == 1;
        if (reset) begin
            exp_q.delete();
            m_lock = -1; m_starve = 0; m_err = 1'b0;
            inst_acc = 1'b0; data_acc = 1'b0;
        end else begin
            if (m_acc) exp_q.push_back(g == 1);
            m_lock = (m_req && !mem_addr_ok) ? g : -1;
            if (!inst_req) m_starve = 0;
            else if (m_acc && g == 0) m_starve = 0;
            else if (m_acc && g == 1 && m_starve < STARVE_MAX) m_starve++;
        end
    end

    task automatic new_inst();
        inst_wr    = 1'($urandom);
        inst_size  = 2'($urandom);
        inst_wstrb = 4'($urandom);
        inst_addr  = $urandom;
        inst_wdata = $urandom;
    endtask

    task automatic new_data();
        data_wr    = 1'($urandom);
        data_size  = 2'($urandom);
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
    endtask

    // One cycle of protocol-correct random traffic (requests held until accepted)
    task automatic rnd_cyc(input int pi, input int pd, input int paok, input int pdok);
        @(posedge clk); #1;
        if (!inst_req || inst_acc) begin inst_req = ($urandom_range(99) < pi); new_inst(); end
        if (!data_req || data_acc) begin data_req = ($urandom_range(99) < pd); new_data(); end
        mem_addr_ok = ($urandom_range(99) < paok);
        mem_data_ok = (exp_q.size() > 0) && ($urandom_range(99) < pdok);
        mem_rdata   = $urandom;
    endtask

    task automatic idle_cyc(input bit rst, input bit dok);
        @(posedge clk); #1;
        reset = rst; inst_req = 1'b0; data_req = 1'b0;
        mem_addr_ok = 1'b1; mem_data_ok = dok; mem_rdata = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin idle_cyc(1'b0, 1'b1); n++; end
        chk("drain_bound", 32'(exp_q.size()), 32'd0);
        idle_cyc(1'b0, 1'b0);
    endtask

    bit exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        reset = 1'b1; inst_req = 1'b0; data_req = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
        new_inst(); new_data();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #2;
        chk("reset_ost_cnt", 32'(ost_cnt), 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);

        repeat (400) rnd_cyc(60, 60, 70, 50);
        repeat (300) rnd_cyc(70, 70, 30, 20);
        repeat (300) rnd_cyc(50, 80, 90, 80);
        drain();

        // Starvation guard: both masters held, immediate accept and response
        idle_cyc(1'b1, 1'b0);
        idle_cyc(1'b0, 1'b0);
        grant_log.delete();
        @(posedge clk); #1;
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
        log_en = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            mem_data_ok = (exp_q.size() > 0);
        end
        log_en = 1'b0;
        inst_req = 1'b0; data_req = 1'b0;
        chk("grant_seq_len", 32'(grant_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk($sformatf("grant_seq[%0d]", i), 32'(grant_log[i]), 32'(exp_seq[i]));
        drain();

        // Unexpected response sets a sticky error, reset clears it
        idle_cyc(1'b0, 1'b1);
        repeat (3) idle_cyc(1'b0, 1'b0);
        @(negedge clk); #2;
        chk("resp_err_sticky", 32'(resp_err), 32'd1);
        idle_cyc(1'b1, 1'b0);
        idle_cyc(1'b0, 1'b0);
        @(negedge clk); #2;
        chk("resp_err_cleared", 32'(resp_err), 32'd0);
        chk("ost_cnt_cleared", 32'(ost_cnt), 32'd0);

        // Reset with a request outstanding discards its tag
        @(posedge clk); #1;
        data_req = 1'b1; new_data(); mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
        @(posedge clk); #1;
        data_req = 1'b0;
        @(negedge clk); #2;
        chk("midop_ost_cnt", 32'(ost_cnt), 32'd1);
        idle_cyc(1'b1, 1'b0);
        idle_cyc(1'b0, 1'b1);
        idle_cyc(1'b0, 1'b0);
        @(negedge clk); #2;
        chk("midop_resp_err", 32'(resp_err), 32'd1);
        chk("midop_ost_zero", 32'(ost_cnt), 32'd0);
        idle_cyc(1'b1, 1'b0);
        idle_cyc(1'b0, 1'b0);
        @(negedge clk); #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
